psum_accum_sfu: RTL and testbench



---
 rtl/psum_accum_sfu.sv | 124 ++++++++++++
 tb/tb_psum_accum_sfu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_sfu.sv
// rtl/psum_accum_sfu.sv - multi-pass psum accumulator with optional ReLU and valid/ready drain
module psum_accum_sfu #(
  parameter int psum_bw = 16,
  parameter int col     = 4,
  parameter int depth   = 16,
  parameter int addr_bw = 4,
  parameter int pass_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw:0]         cfg_len,
  input  logic [pass_bw-1:0]       cfg_pass,
  input  logic                     relu_en,
  input  logic [col*psum_bw-1:0]   psum_in,
  input  logic                     psum_valid,
  output logic                     rd_ofifo,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                 state;
  logic [addr_bw-1:0]     idx;
  logic [pass_bw-1:0]     pass_cnt;
  logic [addr_bw:0]       len_q;
  logic [pass_bw-1:0]     pass_q;
  logic                   relu_q;

  logic [col*psum_bw-1:0] acc_mem [depth];
  logic [col*psum_bw-1:0] entry;
  logic [col*psum_bw-1:0] sum_vec;
  logic [psum_bw-1:0]     lane;
  logic                   pop;
  logic                   last_idx;
  logic                   last_pass;

  assign pop       = (state == ACC) && psum_valid;
  assign rd_ofifo  = pop;
  assign entry     = acc_mem[idx];
  assign last_idx  = ({1'b0, idx} == len_q - (addr_bw+1)'(1));
  assign last_pass = (pass_cnt == pass_q - pass_bw'(1));
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Pass 0 overwrites, so stale buffer contents from earlier jobs never leak in.
  always_comb begin
    sum_vec = '0;
    for (int k = 0; k < col; k++) begin
      if (pass_cnt == '0)
        sum_vec[k*psum_bw +: psum_bw] = psum_in[k*psum_bw +: psum_bw];
      else
        sum_vec[k*psum_bw +: psum_bw] = entry[k*psum_bw +: psum_bw] + psum_in[k*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out_data = '0;
    lane     = '0;
    if (state == DRAIN) begin
      for (int k = 0; k < col; k++) begin
        lane = entry[k*psum_bw +: psum_bw];
        out_data[k*psum_bw +: psum_bw] = (relu_q && lane[psum_bw-1]) ? '0 : lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      acc_mem[idx] <= sum_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
      pass_q   <= '0;
      relu_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= (cfg_len > (addr_bw+1)'(depth)) ? (addr_bw+1)'(depth) : cfg_len;
            pass_q   <= cfg_pass;
            relu_q   <= relu_en;
            idx      <= '0;
            pass_cnt <= '0;
            state    <= (cfg_len == '0 || cfg_pass == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (pop) begin
            if (last_idx) begin
              idx      <= '0;
              pass_cnt <= pass_cnt + pass_bw'(1);
              if (last_pass)
                state <= DRAIN;
            end else begin
              idx <= idx + addr_bw'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_idx)
              state <= DONE;
            else
              idx <= idx + addr_bw'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// tb/tb_psum_accum_sfu.sv - scoreboard bench for psum_accum_sfu against a pass-sum reference model
module tb_psum_accum_sfu;
  localparam int PB = 16;
  localparam int COL = 4;
  localparam int DEPTH = 16;
  localparam int AB = 4;
  localparam int PSB = 4;
  localparam int W = PB*COL;

  logic          clk, reset, start, relu_en, psum_valid, rd_ofifo, out_valid, out_ready, busy, done;
  logic [AB:0]   cfg_len;
  logic [PSB-1:0] cfg_pass;
  logic [W-1:0]  psum_in, out_data;

  psum_accum_sfu #(.psum_bw(PB), .col(COL), .depth(DEPTH), .addr_bw(AB), .pass_bw(PSB)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_pass(cfg_pass),
    .relu_en(relu_en), .psum_in(psum_in), .psum_valid(psum_valid), .rd_ofifo(rd_ofifo),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int job_pops = 0;
  int done_cnt = 0;
  bit stall_req = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] stim[$];

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(int a, int b, int c, int d);
    logic [W-1:0] v;
    v = {d[PB-1:0], c[PB-1:0], b[PB-1:0], a[PB-1:0]};
    return v;
  endfunction

  // ofifo model and downstream ready generator
  initial begin
    logic pop_seen;
    logic [W-1:0] junk;
    int stall_cnt;
    stall_cnt = 0;
    psum_valid = 1'b0;
    psum_in = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      pop_seen = rd_ofifo;
      @(posedge clk);
      #1;
      if (pop_seen && fifo_q.size() > 0) begin
        junk = fifo_q.pop_front();
        job_pops++;
      end
      if (fifo_q.size() > 0 && ($urandom % 3 != 0)) begin
        psum_valid = 1'b1;
        psum_in = fifo_q[0];
      end else begin
        psum_valid = 1'b0;
        psum_in = {$urandom, $urandom};
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        out_ready = 1'b0;
      end else if (stall_req && out_valid) begin
        stall_req = 0;
        stall_cnt = 4;
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom % 4 != 0);
      end
    end
  end

  // output monitor / scoreboard
  initial begin
    logic have_prev, prev_valid, prev_ready;
    logic [W-1:0] prev_data;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_prev = 0;
      end else begin
        if (rd_ofifo) chk("pop_needs_valid", psum_valid, 1'b1);
        if (have_prev && prev_valid && !prev_ready) begin
          chk("stall_valid_hold", out_valid, 1'b1);
          chk("stall_data_hold", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h expected no output", out_data);
          end else begin
            checks--;
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
        if (!out_valid) chk("out_data_zero_when_invalid", out_data, '0);
        if (done) done_cnt++;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data = out_data;
        have_prev = 1;
      end
    end
  end

  task automatic go(int len, int npass, bit relu);
    @(posedge clk); #2;
    start = 1'b1; cfg_len = len[AB:0]; cfg_pass = npass[PSB-1:0]; relu_en = relu;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Expected output: per entry, per lane, the plain integer sum over passes, wrapped to PB bits.
  task automatic run_job(int len, int npass, bit relu, bit stall, bit poke);
    int eff, s;
    bit got;
    logic [W-1:0] v, w;
    logic signed [PB-1:0] l;
    logic [PB-1:0] t;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int e = 0; e < eff; e++) begin
      v = '0;
      for (int k = 0; k < COL; k++) begin
        s = 0;
        for (int p = 0; p < npass; p++) begin
          w = stim[p*eff + e];
          l = w[k*PB +: PB];
          s += int'(l);
        end
        t = s[PB-1:0];
        if (relu && t[PB-1]) t = '0;
        v[k*PB +: PB] = t;
      end
      exp_q.push_back(v);
    end
    foreach (stim[i]) fifo_q.push_back(stim[i]);
    stim.delete();
    job_pops = 0;
    done_cnt = 0;
    stall_req = stall;
    go(len, npass, relu);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (poke && i == 2) begin start = 1'b1; cfg_len = 1; cfg_pass = 1; end
      if (poke && i == 3) start = 1'b0;
      if (done) got = 1;
    end
    start = 1'b0;
    chk("done_seen", got, 1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("pop_count", job_pops, eff*npass);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("done_one_pulse", done_cnt, 1);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int len, np;
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_pass = '0; relu_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_rd_ofifo", rd_ofifo, 1'b0);
    @(posedge clk); #2 reset = 1'b0;

    stim.push_back(pack(1, 2, 3, 4));
    stim.push_back(pack(-5, 6, -7, 8));
    run_job(2, 1, 0, 0, 0);

    stim.push_back(pack(10, -1, 0, 5));
    stim.push_back(pack(-20, -1, 0, 5));
    stim.push_back(pack(3, -1, 1, 5));
    run_job(1, 3, 1, 0, 0);

    stim.push_back(pack(32767, 0, 0, 0));
    stim.push_back(pack(32767, 0, 0, 0));
    run_job(1, 2, 0, 0, 0);
    stim.push_back(pack(32767, 0, 0, 0));
    stim.push_back(pack(32767, 0, 0, 0));
    run_job(1, 2, 1, 0, 0);

    // cfg_len=0 with data waiting in the ofifo
    fifo_q.push_back(pack(9, 9, 9, 9));
    fifo_q.push_back(pack(7, 7, 7, 7));
    job_pops = 0;
    @(posedge clk); #2;
    start = 1'b1; cfg_len = 0; cfg_pass = 2; relu_en = 0;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("degen_done", done, 1'b1);
    chk("degen_out_valid", out_valid, 1'b0);
    chk("degen_rd_ofifo", rd_ofifo, 1'b0);
    @(negedge clk);
    chk("degen_done_drop", done, 1'b0);
    chk("degen_busy", busy, 1'b0);
    chk("degen_no_pops", job_pops, 0);
    chk("degen_fifo_kept", fifo_q.size(), 2);
    fifo_q.delete();

    // abort a job after 3 of 8 pops
    for (int i = 0; i < 8; i++) fifo_q.push_back({$urandom, $urandom});
    job_pops = 0;
    go(8, 1, 0);
    for (int n = 0; job_pops < 3 && n < 500; n++) begin
      @(posedge clk); #2;
    end
    reset = 1'b1;
    fifo_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_pops", job_pops, 3);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd_ofifo", rd_ofifo, 1'b0);
    @(posedge clk); #2 reset = 1'b0;

    for (int i = 0; i < 4; i++) stim.push_back({$urandom, $urandom});
    run_job(4, 1, 0, 0, 1);

    for (int i = 0; i < 15; i++) stim.push_back({$urandom, $urandom});
    run_job(5, 3, $urandom % 2, 1, 0);

    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 20);
      np = $urandom_range(1, 4);
      for (int i = 0; i < ((len > DEPTH) ? DEPTH : len) * np; i++) stim.push_back({$urandom, $urandom});
      run_job(len, np, $urandom % 2, $urandom % 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
